// File: rtl/tl_resp_demux_pkg.sv
// rtl/tl_resp_demux_pkg.sv - shared TileLink opcodes, sizes and beat-count helper
package tl_resp_demux_pkg;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [31:0] IFETCH_SIZE = 32'h20;
    localparam logic [31:0] DPORT_SIZE  = 32'h10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Beats of a 32-bit data bus; 0 flags a size below one word or not a power of two.
    function automatic logic [31:0] beats_of(input logic [31:0] size);
        if (size < 32'd4 || (size & (size - 32'd1)) != 32'd0) begin
            return 32'd0;
        end
        return size >> 2;
    endfunction

endpackage

// File: rtl/tl_pipe_reg.sv
// rtl/tl_pipe_reg.sv - single-entry valid/ready register, accepts a new entry while draining
module tl_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full;
    logic [W-1:0] data_q;

    assign in_ready  = !full || out_ready;
    assign out_valid = full;
    assign out_data  = data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full   <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/tl_resp_demux.sv
// rtl/tl_resp_demux.sv - D-channel response demux to two masters with burst completion tracking
module tl_resp_demux
    import tl_resp_demux_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              io_in_ready,
    input  logic              io_in_valid,
    input  logic [2:0]        io_in_bits_opcode,
    input  logic [31:0]       io_in_bits_size,
    input  logic              io_in_bits_source,
    input  logic [DATA_W-1:0] io_in_bits_data,
    input  logic              io_out_0_ready,
    output logic              io_out_0_valid,
    output logic [2:0]        io_out_0_bits_opcode,
    output logic [DATA_W-1:0] io_out_0_bits_data,
    input  logic              io_out_1_ready,
    output logic              io_out_1_valid,
    output logic [2:0]        io_out_1_bits_opcode,
    output logic [DATA_W-1:0] io_out_1_bits_data,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_doneSource,
    output logic              io_err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int PAY_W = DATA_W + 5;

    state_t             state, state_n;
    logic               lock_src, lock_src_n;
    logic [CNT_W-1:0]   remaining, remaining_n;
    logic               err, err_n;

    logic               accept, route_src, beat_last, bad_beat;
    logic [31:0]        beats, data_beats;
    logic               full, sel_ready, reg_last, reg_src;
    logic [2:0]         reg_op;
    logic [DATA_W-1:0]  reg_data;
    logic [PAY_W-1:0]   pay_in, pay_out;

    assign data_beats = beats_of(io_in_bits_size);

    always_comb begin
        beats    = 32'd1;
        bad_beat = 1'b0;
        case (io_in_bits_opcode)
            ACCESS_ACK: begin
                beats = 32'd1;
            end
            ACCESS_ACK_DATA: begin
                if (data_beats == 32'd0 || data_beats > 32'(MAX_BEATS)) begin
                    bad_beat = 1'b1;
                end else begin
                    beats = data_beats;
                end
            end
            default: bad_beat = 1'b1;
        endcase
    end

    assign accept    = io_in_valid && io_in_ready;
    assign route_src = (state == IDLE) ? io_in_bits_source : lock_src;

    always_comb begin
        state_n     = state;
        lock_src_n  = lock_src;
        remaining_n = remaining;
        err_n       = err;
        beat_last   = 1'b0;
        if (accept) begin
            if (state == IDLE) begin
                lock_src_n  = io_in_bits_source;
                remaining_n = CNT_W'(beats - 32'd1);
                beat_last   = (beats == 32'd1);
                state_n     = beat_last ? IDLE : BURST;
                if (bad_beat) err_n = 1'b1;
            end else begin
                remaining_n = remaining - CNT_W'(1);
                beat_last   = (remaining_n == '0);
                if (beat_last) state_n = IDLE;
                // Stray-source beats stay on the locked master so the burst count stays coherent.
                if (io_in_bits_source != lock_src) err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lock_src  <= 1'b0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            lock_src  <= lock_src_n;
            remaining <= remaining_n;
            err       <= err_n;
        end
    end

    assign pay_in = {beat_last, route_src, io_in_bits_opcode, io_in_bits_data};
    assign {reg_last, reg_src, reg_op, reg_data} = pay_out;
    assign sel_ready = reg_src ? io_out_1_ready : io_out_0_ready;

    tl_pipe_reg #(.W(PAY_W)) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (io_in_valid),
        .in_ready  (io_in_ready),
        .in_data   (pay_in),
        .out_valid (full),
        .out_ready (sel_ready),
        .out_data  (pay_out)
    );

    assign io_out_0_valid       = full && !reg_src;
    assign io_out_0_bits_opcode = io_out_0_valid ? reg_op : 3'd0;
    assign io_out_0_bits_data   = io_out_0_valid ? reg_data : '0;
    assign io_out_1_valid       = full && reg_src;
    assign io_out_1_bits_opcode = io_out_1_valid ? reg_op : 3'd0;
    assign io_out_1_bits_data   = io_out_1_valid ? reg_data : '0;

    assign io_busy       = (state == BURST) || full;
    assign io_done       = full && sel_ready && reg_last;
    assign io_doneSource = reg_src;
    assign io_err        = err;

endmodule

// File: tb/tb_tl_resp_demux.sv
// tb/tb_tl_resp_demux.sv - directed self-checking bench for tl_resp_demux
module tb_tl_resp_demux;
    import tl_resp_demux_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_ready, io_in_valid;
    logic [2:0]  io_in_bits_opcode;
    logic [31:0] io_in_bits_size;
    logic        io_in_bits_source;
    logic [31:0] io_in_bits_data;
    logic        io_out_0_ready, io_out_0_valid;
    logic [2:0]  io_out_0_bits_opcode;
    logic [31:0] io_out_0_bits_data;
    logic        io_out_1_ready, io_out_1_valid;
    logic [2:0]  io_out_1_bits_opcode;
    logic [31:0] io_out_1_bits_data;
    logic        io_busy, io_done, io_doneSource, io_err;

    always #5 clock = ~clock;

    tl_resp_demux #(.DATA_W(32), .MAX_BEATS(16)) dut (
        .clock(clock), .reset(reset),
        .io_in_ready(io_in_ready), .io_in_valid(io_in_valid),
        .io_in_bits_opcode(io_in_bits_opcode), .io_in_bits_size(io_in_bits_size),
        .io_in_bits_source(io_in_bits_source), .io_in_bits_data(io_in_bits_data),
        .io_out_0_ready(io_out_0_ready), .io_out_0_valid(io_out_0_valid),
        .io_out_0_bits_opcode(io_out_0_bits_opcode), .io_out_0_bits_data(io_out_0_bits_data),
        .io_out_1_ready(io_out_1_ready), .io_out_1_valid(io_out_1_valid),
        .io_out_1_bits_opcode(io_out_1_bits_opcode), .io_out_1_bits_data(io_out_1_bits_data),
        .io_busy(io_busy), .io_done(io_done), .io_doneSource(io_doneSource), .io_err(io_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic toggle0 = 1'b0;
    logic dummy;

    logic [31:0] got0[$], got1[$];
    logic [2:0]  op1[$];
    int          tick0[$], tick1[$];
    logic        dsrc[$];
    int          dat[$];
    int          drains, inflight, seen0, seen1, ready_low, busy_gap;

    task automatic clear_obs();
        got0.delete(); got1.delete(); op1.delete(); tick0.delete(); tick1.delete();
        dsrc.delete(); dat.delete();
        drains = 0; inflight = 0; seen0 = 0; seen1 = 0; ready_low = 0; busy_gap = 0;
    endtask

    // Samples at the falling edge, then advances to just after the next rising edge.
    task automatic tick(output logic acc);
        int d;
        d = 0;
        @(negedge clock);
        acc = io_in_valid && io_in_ready && !reset;
        if (!io_in_ready) ready_low++;
        if (inflight > 0 && !io_busy) busy_gap++;
        if (io_out_0_valid) begin
            seen0++;
            if (io_out_0_ready) begin got0.push_back(io_out_0_bits_data); tick0.push_back(cyc); d++; end
        end
        if (io_out_1_valid) begin
            seen1++;
            if (io_out_1_ready) begin
                got1.push_back(io_out_1_bits_data); op1.push_back(io_out_1_bits_opcode);
                tick1.push_back(cyc); d++;
            end
        end
        drains += d;
        if (io_done) begin dsrc.push_back(io_doneSource); dat.push_back(drains); end
        inflight = inflight + (acc ? 1 : 0) - d;
        @(posedge clock);
        #1;
        cyc++;
        if (toggle0) io_out_0_ready = cyc[0];
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [31:0] size,
                             input logic src, input logic [31:0] data);
        logic acc;
        acc = 1'b0;
        io_in_valid = 1'b1; io_in_bits_opcode = op; io_in_bits_size = size;
        io_in_bits_source = src; io_in_bits_data = data;
        for (int n = 0; n < 16 && !acc; n++) tick(acc);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %0h not accepted, required accept", data);
        end
    endtask

    task automatic idle(input int n);
        io_in_valid = 1'b0;
        repeat (n) tick(dummy);
    endtask

    task automatic do_reset();
        reset = 1'b1; io_in_valid = 1'b0; toggle0 = 1'b0;
        io_out_0_ready = 1'b1; io_out_1_ready = 1'b1;
        tick(dummy); tick(dummy);
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic test_reset();
        reset = 1'b1; io_in_valid = 1'b0; io_in_bits_opcode = 3'd0; io_in_bits_size = 32'd0;
        io_in_bits_source = 1'b0; io_in_bits_data = 32'd0;
        io_out_0_ready = 1'b0; io_out_1_ready = 1'b0;
        tick(dummy); tick(dummy);
        checks += 7;
        if (io_out_0_valid !== 1'b0) begin errors++; $display("FAIL rst_v0: got %b required 0", io_out_0_valid); end
        if (io_out_1_valid !== 1'b0) begin errors++; $display("FAIL rst_v1: got %b required 0", io_out_1_valid); end
        if (io_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", io_busy); end
        if (io_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", io_done); end
        if (io_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", io_err); end
        if (io_out_0_bits_data !== 32'd0) begin errors++; $display("FAIL rst_data0: got %h required 0", io_out_0_bits_data); end
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", io_in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single_ack();
        do_reset();
        send_beat(ACCESS_ACK, 32'd0, 1'b1, 32'h5A);
        io_in_valid = 1'b0;
        #1;
        checks += 4;
        if (io_out_1_valid !== 1'b1) begin errors++; $display("FAIL ack_v1: got %b required 1", io_out_1_valid); end
        if (io_out_1_bits_opcode !== 3'd0) begin errors++; $display("FAIL ack_op: got %0d required 0", io_out_1_bits_opcode); end
        if (io_out_1_bits_data !== 32'h5A) begin errors++; $display("FAIL ack_data: got %h required 5a", io_out_1_bits_data); end
        if (io_out_0_valid !== 1'b0) begin errors++; $display("FAIL ack_v0: got %b required 0", io_out_0_valid); end
        idle(3);
        checks += 3;
        if (dsrc.size() !== 1) begin errors++; $display("FAIL ack_done_cnt: got %0d required 1", dsrc.size()); end
        else if (dsrc[0] !== 1'b1) begin errors++; $display("FAIL ack_done_src: got %b required 1", dsrc[0]); end
        if (seen0 !== 0) begin errors++; $display("FAIL ack_seen0: got %0d required 0", seen0); end
        if (got1.size() !== 1) begin errors++; $display("FAIL ack_cnt1: got %0d required 1", got1.size()); end
    endtask

    task automatic test_burst_ifetch();
        do_reset();
        for (int i = 0; i < 8; i++) send_beat(ACCESS_ACK_DATA, IFETCH_SIZE, 1'b0, 32'hA0 + 32'(i));
        idle(3);
        checks += 6;
        if (got0.size() !== 8) begin errors++; $display("FAIL if_cnt: got %0d required 8", got0.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got0[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL if_data%0d: got %h required %h", i, got0[i], 32'hA0 + 32'(i)); end
            end
            checks++;
            if (tick0[7] - tick0[0] !== 7) begin errors++; $display("FAIL if_rate: got %0d required 7", tick0[7] - tick0[0]); end
        end
        if (dsrc.size() !== 1) begin errors++; $display("FAIL if_done_cnt: got %0d required 1", dsrc.size()); end
        else if (dsrc[0] !== 1'b0 || dat[0] !== 8) begin errors++; $display("FAIL if_done: got src %b at %0d required src 0 at 8", dsrc[0], dat[0]); end
        if (busy_gap !== 0) begin errors++; $display("FAIL if_busy_gap: got %0d required 0", busy_gap); end
        if (io_busy !== 1'b0) begin errors++; $display("FAIL if_busy_end: got %b required 0", io_busy); end
        if (seen1 !== 0) begin errors++; $display("FAIL if_seen1: got %0d required 0", seen1); end
        if (io_err !== 1'b0) begin errors++; $display("FAIL if_err: got %b required 0", io_err); end
    endtask

    task automatic test_burst_stall();
        do_reset();
        toggle0 = 1'b1; io_out_0_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(ACCESS_ACK_DATA, IFETCH_SIZE, 1'b0, 32'hA0 + 32'(i));
        idle(6);
        toggle0 = 1'b0; io_out_0_ready = 1'b1;
        checks += 3;
        if (ready_low == 0) begin errors++; $display("FAIL st_backpressure: got %0d stalls required >0", ready_low); end
        if (got0.size() !== 8) begin errors++; $display("FAIL st_cnt: got %0d required 8", got0.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got0[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL st_data%0d: got %h required %h", i, got0[i], 32'hA0 + 32'(i)); end
            end
        end
        if (dsrc.size() !== 1) begin errors++; $display("FAIL st_done_cnt: got %0d required 1", dsrc.size()); end
        else begin
            checks++;
            if (dat[0] !== 8) begin errors++; $display("FAIL st_done_at: got %0d required 8", dat[0]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(ACCESS_ACK_DATA, DPORT_SIZE, 1'b1, 32'hB0 + 32'(i));
        send_beat(ACCESS_ACK, 32'd0, 1'b0, 32'hC0);
        idle(3);
        checks += 4;
        if (got1.size() !== 4) begin errors++; $display("FAIL b2b_cnt1: got %0d required 4", got1.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got1[i] !== 32'hB0 + 32'(i)) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", i, got1[i], 32'hB0 + 32'(i)); end
            end
        end
        if (got0.size() !== 1) begin errors++; $display("FAIL b2b_cnt0: got %0d required 1", got0.size()); end
        else begin
            checks += 2;
            if (got0[0] !== 32'hC0) begin errors++; $display("FAIL b2b_ack_data: got %h required c0", got0[0]); end
            if (got1.size() == 4 && tick0[0] !== tick1[3] + 1) begin errors++; $display("FAIL b2b_bubble: got cycle %0d required %0d", tick0[0], tick1[3] + 1); end
        end
        if (dsrc.size() !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d required 2", dsrc.size()); end
        else if (dsrc[0] !== 1'b1 || dsrc[1] !== 1'b0) begin errors++; $display("FAIL b2b_done_src: got %b%b required 10", dsrc[0], dsrc[1]); end
        if (io_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b required 0", io_err); end
    endtask

    task automatic test_src_err();
        do_reset();
        send_beat(ACCESS_ACK_DATA, DPORT_SIZE, 1'b1, 32'hD0);
        send_beat(ACCESS_ACK_DATA, DPORT_SIZE, 1'b0, 32'hD1);
        send_beat(ACCESS_ACK_DATA, DPORT_SIZE, 1'b1, 32'hD2);
        send_beat(ACCESS_ACK_DATA, DPORT_SIZE, 1'b1, 32'hD3);
        idle(2);
        checks += 4;
        if (io_err !== 1'b1) begin errors++; $display("FAIL se_err: got %b required 1", io_err); end
        if (got1.size() !== 4) begin errors++; $display("FAIL se_cnt1: got %0d required 4", got1.size()); end
        else if (got1[1] !== 32'hD1) begin errors++; $display("FAIL se_stray: got %h required d1", got1[1]); end
        if (seen0 !== 0) begin errors++; $display("FAIL se_seen0: got %0d required 0", seen0); end
        if (dsrc.size() !== 1) begin errors++; $display("FAIL se_done: got %0d required 1", dsrc.size()); end
        idle(4);
        checks++;
        if (io_err !== 1'b1) begin errors++; $display("FAIL se_sticky: got %b required 1", io_err); end
    endtask

    task automatic test_sizes();
        do_reset();
        for (int i = 0; i < 16; i++) send_beat(ACCESS_ACK_DATA, 32'h40, 1'b1, 32'h100 + 32'(i));
        idle(3);
        checks += 2;
        if (dsrc.size() !== 1 || dat.size() !== 1) begin errors++; $display("FAIL max_done_cnt: got %0d required 1", dsrc.size()); end
        else if (dat[0] !== 16) begin errors++; $display("FAIL max_done_at: got %0d required 16", dat[0]); end
        if (io_err !== 1'b0) begin errors++; $display("FAIL max_err: got %b required 0", io_err); end
        do_reset();
        send_beat(ACCESS_ACK_DATA, 32'h80, 1'b1, 32'hE0);
        idle(3);
        checks += 2;
        if (dsrc.size() !== 1 || dat.size() !== 1) begin errors++; $display("FAIL big_done_cnt: got %0d required 1", dsrc.size()); end
        else if (dat[0] !== 1) begin errors++; $display("FAIL big_done_at: got %0d required 1", dat[0]); end
        if (io_err !== 1'b1) begin errors++; $display("FAIL big_err: got %b required 1", io_err); end
        do_reset();
        send_beat(ACCESS_ACK_DATA, 32'h0C, 1'b0, 32'hE1);
        idle(3);
        checks += 2;
        if (dsrc.size() !== 1 || got0.size() !== 1) begin errors++; $display("FAIL npow2_done_cnt: got %0d required 1", dsrc.size()); end
        if (io_err !== 1'b1) begin errors++; $display("FAIL npow2_err: got %b required 1", io_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_beat(ACCESS_ACK_DATA, IFETCH_SIZE, 1'b0, 32'hA0);
        send_beat(ACCESS_ACK_DATA, IFETCH_SIZE, 1'b0, 32'hA1);
        io_in_bits_data = 32'hA2;
        reset = 1'b1;
        tick(dummy);
        checks += 5;
        if (io_out_0_valid !== 1'b0) begin errors++; $display("FAIL rm_v0: got %b required 0", io_out_0_valid); end
        if (io_out_1_valid !== 1'b0) begin errors++; $display("FAIL rm_v1: got %b required 0", io_out_1_valid); end
        if (io_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b required 0", io_busy); end
        if (io_done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b required 0", io_done); end
        if (dsrc.size() !== 0) begin errors++; $display("FAIL rm_no_done: got %0d required 0", dsrc.size()); end
        reset = 1'b0; io_in_valid = 1'b0;
        clear_obs();
        send_beat(ACCESS_ACK, 32'd0, 1'b0, 32'hF0);
        idle(3);
        checks += 3;
        if (dsrc.size() !== 1) begin errors++; $display("FAIL rm_after_done: got %0d required 1", dsrc.size()); end
        else if (dsrc[0] !== 1'b0) begin errors++; $display("FAIL rm_after_src: got %b required 0", dsrc[0]); end
        if (got0.size() !== 1) begin errors++; $display("FAIL rm_after_cnt: got %0d required 1", got0.size()); end
        else if (got0[0] !== 32'hF0) begin errors++; $display("FAIL rm_after_data: got %h required f0", got0[0]); end
        if (io_busy !== 1'b0) begin errors++; $display("FAIL rm_after_busy: got %b required 0", io_busy); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_single_ack();
        test_burst_ifetch();
        test_burst_stall();
        test_back_to_back();
        test_src_err();
        test_sizes();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
